ksz_bus_cycle: RTL
==================

Name: ksz_bus_cycle

Overview:
Host-bus cycle engine for the KSZ8851 16-bit parallel interface, directly downstream of the transmit sequencer. Consumes per-command requests (NewCommand, WR, offset, length, writeData, Dummy_Write) and sequences one register access or one data-only (dummy-address) word write.
Drives CSn/CMD/RDn/WRn and the SD bus, returns readData, and publishes its 4-bit `state` so the sequencer can step on Read1/Write1/Read2/Write2/Addr0/Wait.

Parameters:
SETUP_EXT, 0, extra sysclk cycles spent in Addr0, Read0 and Write0 (0..15), to meet chip setup time.

Ports:
sysclk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
NewCommand  in  1  start a full (address + data) cycle
WR  in  1  1 = register write, 0 = register read
offset  in  8  register byte address
length  in  1  1 = 16-bit word access, 0 = byte access
writeData  in  16  data for write cycles
Dummy_Write  in  1  data-only write cycles to the QMU dummy address
state  out  4  current cycle state (encoding below)
readData  out  16  last word read; held until the next read
ETH_CSn  out  1  chip select, active low
ETH_CMD  out  1  1 = command/address phase, 0 = data phase
ETH_RDn  out  1  read strobe, active low
ETH_WRn  out  1  write strobe, active low
SD_out  out  16  bus value driven when SD_oe = 1
SD_oe  out  1  SD tristate enable
SD_in  in  16  bus value from the pad

Behaviour:
- State encoding (fixed, shared with the sequencer):
  - Addr0=0, Addr1=1, Addr2=2
  - Read0=3, Read1=4, Read2=5
  - Write0=6, Write1=7, Write2=8
  - Wait=9
- Reset (any cycle, including mid-cycle):
  - state=Wait, readData=0, SD_out=0, SD_oe=0
  - ETH_CSn=1, ETH_CMD=1, ETH_RDn=1, ETH_WRn=1
  - extension counter=0
- Transitions:
  - Wait: NewCommand=1 -> Addr0; else Dummy_Write=1 -> Write0; else stay in Wait.
  - Addr0 -> Addr1 -> Addr2 -> (WR ? Write0 : Read0). WR is sampled in Addr2.
  - Read0 -> Read1 -> Read2 -> (NewCommand ? Addr0 : Wait).
  - Write0 -> Write1 -> Write2 -> (Dummy_Write ? Write0 : NewCommand ? Addr0 : Wait). Dummy_Write has priority over NewCommand.
  - Addr0, Read0 and Write0 each last 1+SETUP_EXT cycles. All other states last exactly 1 cycle.
- Outputs per state (registered, valid the cycle after state entry unless noted):
  - ETH_CSn = 0 in every state except Wait.
  - ETH_CMD = 1 in Addr0..Addr2 and Wait, 0 elsewhere.
  - ETH_WRn = 0 only in Addr1 and Write1.
  - ETH_RDn = 0 in Read0 and Read1.
  - SD_oe = 1 in Addr0..2 and Write0..2, 0 in Read* and Wait.
- Command word, loaded into SD_out on every Addr0 cycle:
  - Format: {4'b0000, be[3:0], offset[7:2], 2'b00}.
  - length=1: be = offset[1] ? 4'b1100 : 4'b0011.
  - length=0: be = 4'b0001 << offset[1:0].
- Write data: SD_out <= writeData on every Write0 cycle; held through Write1 and Write2. The WRn rising edge (entry to Addr2/Write2) latches into the chip.
- Read data: readData <= SD_in on the Read1 -> Read2 edge. Valid from Read2 onward; stable in Wait and in the following Addr0 for read-modify-write.
- Inputs are not latched at command start. The sequencer updates offset/WR/length during Read2/Write2/Wait and writeData during Write2/Addr0; this block samples them exactly where stated above.
- Dummy burst: back-to-back Write0/1/2 with ETH_CSn held low and ETH_CMD=0. No address phase is inserted between words.
- NewCommand held high across a cycle simply chains the next access; there is no edge detection.

Test Plan:
- Read 0x78, word (NewCommand=1, WR=0, offset=8'h78, length=1 in Wait, SD_in=16'h0600, SETUP_EXT=0) -> state 9,0,1,2,3,4,5,9; SD_out=16'h0378 during Addr1; RDn low 2 cycles; readData=16'h0600 in Read2 and Wait.
- Write 0x90 <- 16'h0000 -> command word 16'h0390; WRn low in Addr1 and Write1; SD_out=16'h0000 in Write1; SD_oe=0 in Wait afterwards.
- Read-modify-write 0x82 (read returns 16'h0030, writeData=readData|16'h0008 set in Addr0) -> command word 16'h0C80; second access drives SD_out=16'h0038 in Write1.
- Dummy burst: Dummy_Write=1 at the Write2 of the 0x82 write, then 3 words 16'h8000, 16'h011D, 16'hFFFF -> state cycles 6,7,8 three times with no Addr states; Dummy_Write=0 with NewCommand=1 at the last Write2 -> Addr0 next.
- SETUP_EXT=2 read -> Addr0 and Read0 each last 3 cycles; Addr1/Read1/Read2 last 1 cycle; data unchanged.
- reset=1 asserted in Write1 -> next cycle state=9, WRn=1, CSn=1, SD_oe=0, readData=0.

Source files
------------

// File: rtl/ksz_bus_cycle.sv
// KSZ8851 host-bus cycle engine. Sequences one register access (address
// phase followed by a read or write data phase) or one data-only word write
// to the QMU dummy address, and drives the parallel-bus strobes and SD bus
// from registers so the pads see glitch-free levels.
module ksz_bus_cycle #(
    parameter int SETUP_EXT = 0
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        NewCommand,
    input  logic        WR,
    input  logic [7:0]  offset,
    input  logic        length,
    input  logic [15:0] writeData,
    input  logic        Dummy_Write,
    output logic [3:0]  state,
    output logic [15:0] readData,
    output logic        ETH_CSn,
    output logic        ETH_CMD,
    output logic        ETH_RDn,
    output logic        ETH_WRn,
    output logic [15:0] SD_out,
    output logic        SD_oe,
    input  logic [15:0] SD_in
);

    // Encoding is shared with the transmit sequencer; do not renumber.
    typedef enum logic [3:0] {
        S_ADDR0  = 4'd0,
        S_ADDR1  = 4'd1,
        S_ADDR2  = 4'd2,
        S_READ0  = 4'd3,
        S_READ1  = 4'd4,
        S_READ2  = 4'd5,
        S_WRITE0 = 4'd6,
        S_WRITE1 = 4'd7,
        S_WRITE2 = 4'd8,
        S_WAIT   = 4'd9
    } state_e;

    // Last extension count before a setup state may be left.
    localparam logic [3:0] EXT_LAST = 4'(SETUP_EXT);

    state_e      state_q, state_d;
    logic [3:0]  ext_q, ext_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] sd_out_q, sd_out_d;
    logic        oe_q, oe_d;
    logic        csn_q, csn_d;
    logic        cmd_q, cmd_d;
    logic        rdn_q, rdn_d;
    logic        wrn_q, wrn_d;
    logic [3:0]  be;
    logic [15:0] cmd_word;

    // Command word: byte enables for the addressed lane(s) plus dword address.
    always_comb begin
        if (length) be = offset[1] ? 4'b1100 : 4'b0011;
        else        be = 4'b0001 << offset[1:0];
        cmd_word = {4'b0000, be, offset[7:2], 2'b00};
    end

    // Next-state logic; setup states hold until the extension count expires.
    always_comb begin
        state_d = state_q;
        ext_d   = 4'd0;
        case (state_q)
            S_WAIT: begin
                if (NewCommand)       state_d = S_ADDR0;
                else if (Dummy_Write) state_d = S_WRITE0;
            end
            S_ADDR0: begin
                if (ext_q == EXT_LAST) state_d = S_ADDR1;
                else                   ext_d   = ext_q + 4'd1;
            end
            S_ADDR1: state_d = S_ADDR2;
            S_ADDR2: state_d = WR ? S_WRITE0 : S_READ0;
            S_READ0: begin
                if (ext_q == EXT_LAST) state_d = S_READ1;
                else                   ext_d   = ext_q + 4'd1;
            end
            S_READ1: state_d = S_READ2;
            S_READ2: state_d = NewCommand ? S_ADDR0 : S_WAIT;
            S_WRITE0: begin
                if (ext_q == EXT_LAST) state_d = S_WRITE1;
                else                   ext_d   = ext_q + 4'd1;
            end
            S_WRITE1: state_d = S_WRITE2;
            S_WRITE2: begin
                // A pending dummy word beats a new command so bursts stay contiguous.
                if (Dummy_Write)     state_d = S_WRITE0;
                else if (NewCommand) state_d = S_ADDR0;
                else                 state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Strobes decoded from the upcoming state so they line up with `state`;
    // SD/readData capture on the edge that leaves the sampling state.
    always_comb begin
        csn_d    = (state_d == S_WAIT);
        cmd_d    = (state_d == S_ADDR0) || (state_d == S_ADDR1) ||
                   (state_d == S_ADDR2) || (state_d == S_WAIT);
        rdn_d    = !((state_d == S_READ0) || (state_d == S_READ1));
        wrn_d    = !((state_d == S_ADDR1) || (state_d == S_WRITE1));
        oe_d     = (state_d == S_ADDR0)  || (state_d == S_ADDR1)  ||
                   (state_d == S_ADDR2)  || (state_d == S_WRITE0) ||
                   (state_d == S_WRITE1) || (state_d == S_WRITE2);
        sd_out_d = sd_out_q;
        rdata_d  = rdata_q;
        if (state_q == S_ADDR0)       sd_out_d = cmd_word;
        else if (state_q == S_WRITE0) sd_out_d = writeData;
        if (state_q == S_READ1)       rdata_d  = SD_in;
    end

    // State, counter and registered bus outputs with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            ext_q    <= 4'd0;
            rdata_q  <= 16'h0000;
            sd_out_q <= 16'h0000;
            oe_q     <= 1'b0;
            csn_q    <= 1'b1;
            cmd_q    <= 1'b1;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            rdata_q  <= rdata_d;
            sd_out_q <= sd_out_d;
            oe_q     <= oe_d;
            csn_q    <= csn_d;
            cmd_q    <= cmd_d;
            rdn_q    <= rdn_d;
            wrn_q    <= wrn_d;
        end
    end

    assign state    = state_q;
    assign readData = rdata_q;
    assign SD_out   = sd_out_q;
    assign SD_oe    = oe_q;
    assign ETH_CSn  = csn_q;
    assign ETH_CMD  = cmd_q;
    assign ETH_RDn  = rdn_q;
    assign ETH_WRn  = wrn_q;

endmodule
